// File: rtl/serial_mod_div_if.sv
// serial_mod_div_if: handshake bundle between a word producer/result consumer and
// serial_mod_div.
//   in_valid / in_ready / in_data      : word offer, producer -> checker
//   out_valid / out_ready / divisible  : result offer, checker -> consumer
//   remainder                          : residue, only when DIV_REM_OUT_EN is defined
// Modports: master = producer/consumer side, slave = the checker.
interface serial_mod_div_if #(
    parameter int unsigned DATA_W = 8
`ifdef DIV_REM_OUT_EN
    , parameter int unsigned RES_W = 2
`endif
);
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic              divisible;
`ifdef DIV_REM_OUT_EN
    logic [RES_W-1:0]  remainder;
`endif

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
`ifdef DIV_REM_OUT_EN
        input  remainder,
`endif
        input  divisible
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
`ifdef DIV_REM_OUT_EN
        output remainder,
`endif
        output divisible
    );
endinterface

// File: rtl/serial_mod_div.sv
// serial_mod_div: sequential divisibility checker. Accepts a DATA_W-bit word, folds it
// MSB-first BITS_PER_CYCLE bits per clock into a residue modulo DIVISOR, then offers the
// divisible flag (and optionally the residue) until the consumer takes it.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : serial_mod_div_if.slave (input word handshake, result handshake)
// Optional feature: define DIV_REM_OUT_EN to export the residue on bus.remainder.
module serial_mod_div #(
    parameter int unsigned DATA_W         = 8,
    parameter int unsigned DIVISOR        = 3,
    parameter int unsigned BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    serial_mod_div_if.slave bus
);
    localparam int unsigned N     = DATA_W / BITS_PER_CYCLE;
    localparam int unsigned RES_W = ($clog2(DIVISOR) > 1) ? $clog2(DIVISOR) : 1;
    localparam int unsigned CNT_W = $clog2(N + 1);
    localparam int unsigned ACC_W = RES_W + BITS_PER_CYCLE;

    // Divisor at accumulator width; it always fits since DIVISOR <= 2^RES_W.
    localparam logic [ACC_W-1:0] DIV_C    = ACC_W'(DIVISOR);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StBusy = 2'd1;
    localparam logic [1:0] StDone = 2'd2;

    logic [1:0]        state_q, state_d;
    logic [DATA_W-1:0] sh_q, sh_d;
    logic [RES_W-1:0]  res_q, res_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic [ACC_W-1:0]  acc;
    logic [RES_W-1:0]  res_next;

    // Horner step: shift the residue up by K bits, append the next chunk, reduce.
    assign acc      = {res_q, sh_q[DATA_W-1 -: BITS_PER_CYCLE]};
    assign res_next = RES_W'(acc % DIV_C);

    always_comb begin
        state_d = state_q;
        sh_d    = sh_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        case (state_q)
            StIdle: begin
                if (bus.in_valid) begin
                    sh_d    = bus.in_data;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                sh_d  = sh_q << BITS_PER_CYCLE;
                res_d = res_next;
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_LAST) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                if (bus.out_ready) begin
                    // A word offered during the result transfer is taken on the same edge.
                    if (bus.in_valid) begin
                        sh_d    = bus.in_data;
                        res_d   = '0;
                        cnt_d   = '0;
                        state_d = StBusy;
                    end else begin
                        state_d = StIdle;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            sh_q    <= '0;
            res_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            sh_q    <= sh_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.in_ready  = !rst && ((state_q == StIdle) ||
                                    ((state_q == StDone) && bus.out_ready));
    assign bus.out_valid = (state_q == StDone);
    assign bus.divisible = (state_q == StDone) && (res_q == '0);
`ifdef DIV_REM_OUT_EN
    assign bus.remainder = (state_q == StDone) ? res_q : '0;
`endif

endmodule

// File: tb/tb_serial_mod_div.sv
// tb_serial_mod_div: directed bench for serial_mod_div. Instance a uses the default
// parameters (mod 3, 1 bit/cycle); instance b uses DIVISOR=7, BITS_PER_CYCLE=2.
// Remainder checks are included when DIV_REM_OUT_EN is defined.
module tb_serial_mod_div;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

`ifdef DIV_REM_OUT_EN
    serial_mod_div_if #(.DATA_W(8), .RES_W(2)) a ();
    serial_mod_div_if #(.DATA_W(8), .RES_W(3)) b ();
`else
    serial_mod_div_if #(.DATA_W(8)) a ();
    serial_mod_div_if #(.DATA_W(8)) b ();
`endif

    serial_mod_div #(.DATA_W(8), .DIVISOR(3), .BITS_PER_CYCLE(1)) u_dut_a (
        .clk (clk),
        .rst (rst),
        .bus (a.slave)
    );

    serial_mod_div #(.DATA_W(8), .DIVISOR(7), .BITS_PER_CYCLE(2)) u_dut_b (
        .clk (clk),
        .rst (rst),
        .bus (b.slave)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at the first falling edge after the accepting edge; counts edges until
    // out_valid appears, bounded so a dead DUT cannot hang the run.
    task automatic wait_out_a(output int lat);
        lat = 0;
        while (!a.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic wait_out_b(output int lat);
        lat = 0;
        while (!b.out_valid && lat < 50) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic run_a(input logic [7:0] v, input int stall, input string tag);
        int         lat;
        logic       exp_div;
        logic [1:0] exp_rem;
        exp_div = ((v % 3) == 0);
        exp_rem = 2'(v % 3);
        a.in_data   = v;
        a.in_valid  = 1'b1;
        a.out_ready = 1'b0;
        #1;
        chk({tag, "_in_ready"}, 32'(a.in_ready), 32'd1);
        @(negedge clk);
        a.in_valid = 1'b0;
        a.in_data  = ~v;  // must not disturb the word already captured
        wait_out_a(lat);
        chk({tag, "_latency"}, 32'(lat), 32'd8);
        chk({tag, "_divisible"}, 32'(a.divisible), 32'(exp_div));
`ifdef DIV_REM_OUT_EN
        chk({tag, "_remainder"}, 32'(a.remainder), 32'(exp_rem));
`endif
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk({tag, "_hold_valid"}, 32'(a.out_valid), 32'd1);
            chk({tag, "_hold_div"}, 32'(a.divisible), 32'(exp_div));
        end
        a.out_ready = 1'b1;
        @(negedge clk);
        a.out_ready = 1'b0;
        chk({tag, "_valid_drop"}, 32'(a.out_valid), 32'd0);
    endtask

    task automatic run_b(input logic [7:0] v, input logic exp_div, input logic [2:0] exp_rem,
                         input string tag);
        int lat;
        b.in_data  = v;
        b.in_valid = 1'b1;
        @(negedge clk);
        b.in_valid = 1'b0;
        wait_out_b(lat);
        chk({tag, "_latency"}, 32'(lat), 32'd4);
        chk({tag, "_divisible"}, 32'(b.divisible), 32'(exp_div));
`ifdef DIV_REM_OUT_EN
        chk({tag, "_remainder"}, 32'(b.remainder), 32'(exp_rem));
`else
        if (exp_rem > 3'd6) $display("unexpected residue %0d", exp_rem);
`endif
        @(negedge clk);  // out_ready is held high on b, so the result is taken here
        chk({tag, "_valid_drop"}, 32'(b.out_valid), 32'd0);
    endtask

    initial begin
        int lat;
        int seen;
        a.in_valid = 1'b0; a.in_data = '0; a.out_ready = 1'b0;
        b.in_valid = 1'b0; b.in_data = '0; b.out_ready = 1'b1;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(a.in_ready), 32'd0);
        chk("rst_out_valid", 32'(a.out_valid), 32'd0);
        chk("rst_divisible", 32'(a.divisible), 32'd0);
`ifdef DIV_REM_OUT_EN
        chk("rst_remainder", 32'(a.remainder), 32'd0);
`endif
        rst = 1'b0;
        #1;
        chk("post_rst_in_ready", 32'(a.in_ready), 32'd1);
        chk("post_rst_in_ready_b", 32'(b.in_ready), 32'd1);

        // Basic words
        run_a(8'd9, 0, "w9");
        chk("w9_idle", 32'(a.in_ready), 32'd1);
        run_a(8'd10, 0, "w10");
        run_a(8'd255, 1, "w255");
        run_a(8'd0, 0, "w0");

        // Backpressure then same-edge accept of a new word
        a.in_data  = 8'd12;
        a.in_valid = 1'b1;
        @(negedge clk);
        a.in_valid = 1'b0;
        wait_out_a(lat);
        chk("bp_latency", 32'(lat), 32'd8);
        for (int i = 0; i < 5; i++) begin
            chk("bp_valid", 32'(a.out_valid), 32'd1);
            chk("bp_div", 32'(a.divisible), 32'd1);
            chk("bp_in_ready", 32'(a.in_ready), 32'd0);
`ifdef DIV_REM_OUT_EN
            chk("bp_rem", 32'(a.remainder), 32'd0);
`endif
            @(negedge clk);
        end
        a.in_data   = 8'd6;
        a.in_valid  = 1'b1;
        a.out_ready = 1'b1;
        #1;
        chk("b2b_in_ready", 32'(a.in_ready), 32'd1);
        @(negedge clk);
        a.in_valid  = 1'b0;
        a.out_ready = 1'b0;
        chk("b2b_valid_drop", 32'(a.out_valid), 32'd0);
        wait_out_a(lat);
        chk("b2b_latency", 32'(lat), 32'd8);
        chk("b2b_div", 32'(a.divisible), 32'd1);
`ifdef DIV_REM_OUT_EN
        chk("b2b_rem", 32'(a.remainder), 32'd0);
`endif
        a.out_ready = 1'b1;
        @(negedge clk);
        a.out_ready = 1'b0;

        // Reset during BUSY abandons the word
        a.in_data  = 8'd5;
        a.in_valid = 1'b1;
        @(negedge clk);
        a.in_valid = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("midrst_in_ready", 32'(a.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("midrst_valid", 32'(a.out_valid), 32'd0);
        chk("midrst_div", 32'(a.divisible), 32'd0);
        chk("midrst_idle", 32'(a.in_ready), 32'd1);
`ifdef DIV_REM_OUT_EN
        chk("midrst_rem", 32'(a.remainder), 32'd0);
`endif
        seen = 0;
        repeat (12) begin
            @(negedge clk);
            if (a.out_valid) seen++;
        end
        chk("midrst_no_pulse", 32'(seen), 32'd0);
        run_a(8'd3, 0, "after_rst");

        // DIVISOR=7, two bits per cycle
        run_b(8'd100, 1'b0, 3'd2, "d7_100");
        run_b(8'd98,  1'b1, 3'd0, "d7_98");
        run_b(8'd255, 1'b0, 3'd3, "d7_255");
        run_b(8'd0,   1'b1, 3'd0, "d7_0");
        run_b(8'd13,  1'b0, 3'd6, "d7_13");

        // Full sweep with random result stalls
        for (int v = 0; v < 256; v++) begin
            run_a(8'(v), int'($urandom_range(0, 3)), "sweep");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/serial_mod_div.md
# serial_mod_div

Parametrised sequential divisibility checker: accepts a DATA_W-bit word over a valid/ready handshake and computes its residue modulo a compile-time DIVISOR. It consumes the word MSB-first, BITS_PER_CYCLE bits per clock. It then presents a divisible flag, plus optionally the remainder, over a second valid/ready handshake. It is the parametrised, multi-cycle successor to the fixed 8-bit combinational divide-by-3 check, for use in datapaths where area matters more than latency.

## Interface

- DATA_W, 8: input word width, ≥ 1.
- DIVISOR, 3: constant modulus, ≥ 2.
- BITS_PER_CYCLE, 1: bits consumed per BUSY cycle, K; must divide DATA_W.
- Derived values:
  - N = DATA_W / BITS_PER_CYCLE, the number of BUSY cycles.
  - RES_W = max(1, $clog2(DIVISOR)).
- clk  input  1  sole clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  input word offered.
- in_ready  output  1  block can accept a word this cycle.
- in_data  input  DATA_W  word to test, unsigned.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes the result this cycle.
- divisible  output  1  1 when in_data mod DIVISOR == 0.
- remainder  output  RES_W  in_data mod DIVISOR; present only with DIV_REM_OUT_EN.

## Operation

- FSM states: IDLE, BUSY, DONE. Registers: sh (DATA_W), res (RES_W), cnt ($clog2(N+1)).
- IDLE
  - in_ready = 1.
  - On in_valid: sh ← in_data, res ← 0, cnt ← 0, go to BUSY.
- BUSY
  - in_ready = 0.
  - Each cycle, chunk = top K bits of sh:
    - res ← (res·2^K + chunk) mod DIVISOR.
    - sh ← sh << K.
    - cnt ← cnt + 1.
  - On the update where cnt reaches N: go to DONE.
- Arithmetic rules
  - The intermediate res·2^K + chunk is RES_W+K bits wide and is always < DIVISOR·2^K.
  - The mod reduction is combinational, by constant, within one cycle.
  - res is always < DIVISOR.
- DONE
  - out_valid = 1.
  - divisible = (res == 0); remainder = res.
  - Result outputs are held stable while out_valid=1 and out_ready=0.
- Leaving DONE
  - On out_ready: go to IDLE.
  - If in_valid is also high in the same cycle, accept the new word and go straight to BUSY; in_ready = out_ready in DONE.
- in_data is sampled only on the accept edge; later changes to it are ignored.
- in_valid while BUSY is ignored (in_ready = 0); the producer must hold the word.

## Timing

- Reset
  - Forces IDLE; out_valid=0, divisible=0, remainder=0, res=0, cnt=0.
  - in_ready=0 while rst=1; in_ready=1 the first cycle after rst falls.
- Reset mid-BUSY or mid-DONE: the operation is abandoned with no output. A held result is lost.
- Latency: out_valid rises exactly N rising edges after the accepting edge. Default configuration: 8 cycles.
- Throughput, back-to-back: one word per N+1 cycles.
- Output handshake:
  - Transfer occurs on an edge where out_valid && out_ready.
  - out_valid falls the next cycle unless a new result is ready; it cannot be, since N ≥ 1.
- in_ready, out_valid, divisible and remainder are functions of registered state, except in_ready in DONE, which follows out_ready combinationally.

## Configuration

- Macro DIV_REM_OUT_EN.
- Defined: the remainder port exists and carries res in DONE. It is 0 in all other states.
- Undefined:
  - No remainder port.
  - res is still computed internally; only divisible is exported.
  - Cycle behaviour is identical in both builds.

## Test plan

- Default parameters, in_data=9, out_ready=1:
  - out_valid exactly 8 cycles after accept.
  - divisible=1, remainder=0.
  - Then IDLE.
- in_data=10, then in_data=255 (default parameters):
  - 10 → divisible=0, remainder=1.
  - 255 → divisible=1, remainder=0.
- DIVISOR=7, BITS_PER_CYCLE=2, in_data=100:
  - out_valid 4 cycles after accept.
  - remainder=2, divisible=0.
- Backpressure:
  - out_ready held 0 for 5 cycles in DONE: out_valid, divisible and remainder stay constant; in_ready=0.
  - Then out_ready=1 with in_valid=1, in_data=6: new word accepted on the same edge; next result divisible=1 after 8 cycles.
- Reset mid-BUSY:
  - rst pulsed at cycle 4 of BUSY: next cycle all outputs 0, state IDLE, no out_valid pulse.
  - A fresh word 3 then gives divisible=1.
- Random sweep: all 256 values with default parameters and random out_ready stalls. Expected divisible = (v%3==0) and remainder = v%3 each time.
